// File: rtl/regfile_sweep_if.sv
// Register-file port bundle: two read ports, one write port, debug tap and ready flag.
// The datapath side holds the master modport and the register file holds the slave modport.
interface regfile_sweep_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] ad1;
  logic [ADDRESS_WIDTH-1:0] ad2;
  logic [ADDRESS_WIDTH-1:0] ad3;
  logic                     we3;
  logic [DATA_WIDTH-1:0]    wd3;
  logic [DATA_WIDTH-1:0]    rd1;
  logic [DATA_WIDTH-1:0]    rd2;
  logic [DATA_WIDTH-1:0]    a0;
  logic                     ready;

  modport master (output ad1, ad2, ad3, we3, wd3, input rd1, rd2, a0, ready);
  modport slave  (input ad1, ad2, ad3, we3, wd3, output rd1, rd2, a0, ready);
endinterface

// File: rtl/regfile_sweep.sv
// Dual-read, single-write register file with optional zero register and write bypass.
// Reset starts a one-entry-per-cycle clear sweep; ready rises once every entry holds zero.
module regfile_sweep #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEBUG_REG     = 10,
  parameter int ZERO_REG_EN   = 1,
  parameter int BYPASS_EN     = 1
) (
  input logic              clk,
  input logic              rst_n,
  regfile_sweep_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] DBG_ADDR  = ADDRESS_WIDTH'(DEBUG_REG);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  logic                     mem_we_s;
  logic [ADDRESS_WIDTH-1:0] mem_wa_s;
  logic [DATA_WIDTH-1:0]    mem_wd_s;
  logic [DATA_WIDTH-1:0]    rd1_s, rd2_s, a0_s;

  // Zero register outranks bypass; nothing is visible until the sweep completes.
  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]    stored,
    input logic                     in_idle,
    input logic                     we,
    input logic [ADDRESS_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0]    wdata
  );
    logic [DATA_WIDTH-1:0] val;
    if (!in_idle) begin
      val = '0;
    end else if ((ZERO_REG_EN != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS_EN != 0) && we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    mem_we_s = 1'b0;
    mem_wa_s = bus.ad3;
    mem_wd_s = bus.wd3;
    if (!rst_n) begin
      state_d = CLEAR;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_we_s = 1'b1;
          mem_wa_s = cnt_q;
          mem_wd_s = '0;
          cnt_d    = cnt_q + ADDRESS_WIDTH'(1);
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            state_d = CLEAR;
          end
        end
        IDLE: begin
          if (bus.we3 && !((ZERO_REG_EN != 0) && (bus.ad3 == '0))) begin
            mem_we_s = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
        end
        default: begin
          state_d = CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    ready_q <= ready_d;
  end

  // Storage has no reset of its own; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_wa_s] <= mem_wd_s;
    end
  end

  always_comb begin
    rd1_s = read_sel(bus.ad1, mem_q[bus.ad1], state_q == IDLE, bus.we3, bus.ad3, bus.wd3);
    rd2_s = read_sel(bus.ad2, mem_q[bus.ad2], state_q == IDLE, bus.we3, bus.ad3, bus.wd3);
    if (state_q != IDLE) begin
      a0_s = '0;
    end else if ((ZERO_REG_EN != 0) && (DBG_ADDR == '0)) begin
      a0_s = '0;
    end else begin
      a0_s = mem_q[DBG_ADDR];
    end
  end

  assign bus.rd1   = rd1_s;
  assign bus.rd2   = rd2_s;
  assign bus.a0    = a0_s;
  assign bus.ready = ready_q;
endmodule

// File: doc/regfile_sweep.md
Name: regfile_sweep

Overview:
Parametrised successor to the single-write, dual-read register file used by the lab CPU datapath.
- Adds a hardwired zero register and optional write-to-read bypass.
- Adds a configurable debug tap register, generalising the fixed a0 output.
- Adds a synchronous active-low reset that launches a one-register-per-cycle clear sweep, tracked by a small FSM with a ready flag.
The block sits between decode (read addresses) and writeback (ad3/wd3/we3), and drives a0 to the top-level display/testbench.

Parameters:
ADDRESS_WIDTH, 5, register address width; DEPTH = 2**ADDRESS_WIDTH entries
DATA_WIDTH, 32, width of each register
DEBUG_REG, 10, index of the register driven onto a0; must be < DEPTH
ZERO_REG_EN, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary
BYPASS_EN, 1, 1 = same-cycle write data forwarded to rd1/rd2; 0 = reads return stored value only

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
ad1  input  ADDRESS_WIDTH  read address, port 1
ad2  input  ADDRESS_WIDTH  read address, port 2
ad3  input  ADDRESS_WIDTH  write address
we3  input  1  write enable
wd3  input  DATA_WIDTH  write data
rd1  output  DATA_WIDTH  read data, port 1 (combinational)
rd2  output  DATA_WIDTH  read data, port 2 (combinational)
a0  output  DATA_WIDTH  contents of register DEBUG_REG (combinational from storage, never bypassed)
ready  output  1  1 = clear sweep finished and writes accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n is sampled only on the rising edge of clk.
- FSM states: CLEAR, IDLE. Sweep counter cnt is ADDRESS_WIDTH bits.
- Edge with rst_n=0: state<=CLEAR, cnt<=0, ready<=0. Storage is untouched on that edge.
  - This applies from any state, including mid-sweep, which restarts the sweep from 0.
- CLEAR, edge with rst_n=1:
  - reg[cnt]<=0, cnt<=cnt+1.
  - If cnt==DEPTH-1: state<=IDLE, ready<=1, cnt wraps to 0.
  - ready therefore rises after exactly DEPTH post-reset edges (32 for defaults).
- CLEAR: we3 is ignored. rd1, rd2 and a0 read 0 regardless of storage or bypass.
- IDLE, edge with rst_n=1 and we3=1: reg[ad3]<=wd3.
  - Exception: ad3==0 with ZERO_REG_EN=1, in which case the write is dropped.
- IDLE stays IDLE; it leaves only via reset.
- Read path (IDLE), for each port n in {1,2}:
  - ZERO_REG_EN=1 and adn==0 -> rdn=0.
  - Else BYPASS_EN=1, we3=1 and ad3==adn -> rdn=wd3 (new value visible in the same cycle).
  - Else rdn=reg[adn].
  - Zero-register rule has priority over bypass.
- Both read ports may hit the same address and both may be bypassed simultaneously.
- a0 = reg[DEBUG_REG] from storage only. A write to DEBUG_REG appears on a0 the cycle after the edge. With ZERO_REG_EN=1 and DEBUG_REG=0, a0=0.
- Reset values: ready=0; rd1/rd2/a0 = 0 (forced by CLEAR). Storage contents are defined only after the sweep completes.
- No X propagation is permitted after ready=1: every entry has been written with 0.

Test Plan:
- Sweep: hold rst_n=0 for 2 edges, release -> ready=0 for 31 edges and rises on the 32nd post-reset edge. Then every address read on rd1 returns 0x00000000.
- Write/read: ready=1, write 0xDEADBEEF to reg 5 (we3=1, ad3=5) -> next cycle rd1 (ad1=5) = 0xDEADBEEF; rd2 (ad2=6) = 0.
- Bypass: we3=1, ad3=7, wd3=0x12345678, ad1=ad2=7 in the same cycle -> rd1=rd2=0x12345678 before the edge. With BYPASS_EN=0, both return the old value 0.
- Zero reg: write 0xFFFFFFFF to reg 0 with ad1=0 -> rd1=0 in that cycle and after. With ZERO_REG_EN=0, rd1=0xFFFFFFFF after the edge.
- Debug tap: write 0x000000AA to reg 10 -> a0 stays at the old value until the edge, then reads 0x000000AA. A write to reg 11 leaves a0 unchanged.
- Reset mid-operation: write 0x55 to reg 3, assert rst_n=0 for 1 edge at sweep step 10, release -> the sweep restarts at 0, ready rises 32 edges after release, writes issued during CLEAR are discarded, and reg 3 reads 0.
